// File: rtl/debug_panel_ctrl.sv
// Debug front panel: debounced step key, run/step/halt clock-enable FSM, step counter
// on the LEDs and a registered hex display of a selected probe word.
// Optional breakpoint halt is enabled by defining DEBUG_PANEL_BP_EN.
module debug_panel_ctrl #(
  parameter int NUM_CH          = 5,
  parameter int CH_SEL_W        = 3,
  parameter int NUM_HEX         = 6,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LED_W           = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run_mode_i,
  input  logic                  step_key_n_i,
  input  logic [CH_SEL_W-1:0]   chan_sel_i,
  input  logic                  page_sel_i,
  input  logic [NUM_CH*32-1:0]  probe_i,
  input  logic [31:0]           bp_addr_i,
  input  logic                  bp_valid_i,
  output logic                  cpu_en_o,
  output logic                  halted_o,
  output logic [NUM_HEX*7-1:0]  hex_o,
  output logic [LED_W-1:0]      led_o
);

  localparam int CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PAGE_SHIFT = 4 * NUM_HEX;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STEP_IDLE  = 2'd1,
    STEP_PULSE = 2'd2,
    HALT       = 2'd3
  } state_t;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  logic             key_s1_q, key_s2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             press_s;
  logic             bp_rise_s;
  state_t           state_q;
  logic             cpu_en_q, halted_q;
  logic [LED_W-1:0] step_q;
  logic [31:0]      word_s, page_word_s;
  logic [NUM_HEX*7-1:0] hex_d, hex_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
      stable_q <= 1'b1;
      db_cnt_q <= '0;
    end else begin
      key_s1_q <= step_key_n_i;
      key_s2_q <= key_s1_q;
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Any cycle where the synced key agrees with the stable level restarts the count.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    if (key_s2_q != stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        stable_d = key_s2_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + CNT_W'(1);
      end
    end else begin
      db_cnt_d = '0;
    end
  end

  assign press_s = stable_q & ~stable_d;

`ifdef DEBUG_PANEL_BP_EN
  logic match_s, match_q;
  assign match_s   = bp_valid_i && (probe_i[31:0] == bp_addr_i);
  assign bp_rise_s = match_s & ~match_q;

  always_ff @(posedge clk) begin
    if (reset) match_q <= 1'b0;
    else       match_q <= match_s;
  end
`else
  logic unused_bp_s;
  assign unused_bp_s = ^{bp_addr_i, bp_valid_i};
  assign bp_rise_s   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= STEP_IDLE;
      cpu_en_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (bp_rise_s) begin
            state_q <= HALT; cpu_en_q <= 1'b0; halted_q <= 1'b1;
          end else if (!run_mode_i) begin
            state_q <= STEP_IDLE; cpu_en_q <= 1'b0; halted_q <= 1'b0;
          end else begin
            state_q <= RUN; cpu_en_q <= 1'b1; halted_q <= 1'b0;
          end
        end
        STEP_IDLE: begin
          halted_q <= 1'b0;
          if (run_mode_i) begin
            state_q <= RUN; cpu_en_q <= 1'b1;
          end else if (press_s) begin
            state_q <= STEP_PULSE; cpu_en_q <= 1'b1;
          end else begin
            state_q <= STEP_IDLE; cpu_en_q <= 1'b0;
          end
        end
        STEP_PULSE: begin
          halted_q <= 1'b0;
          if (run_mode_i) begin
            state_q <= RUN; cpu_en_q <= 1'b1;
          end else begin
            state_q <= STEP_IDLE; cpu_en_q <= 1'b0;
          end
        end
        HALT: begin
          if (press_s) begin
            state_q <= STEP_PULSE; cpu_en_q <= 1'b1; halted_q <= 1'b0;
          end else if (!run_mode_i) begin
            state_q <= STEP_IDLE; cpu_en_q <= 1'b0; halted_q <= 1'b0;
          end else begin
            state_q <= HALT; cpu_en_q <= 1'b0; halted_q <= 1'b1;
          end
        end
        default: begin
          state_q <= STEP_IDLE; cpu_en_q <= 1'b0; halted_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) step_q <= '0;
    else       step_q <= step_q + {{(LED_W-1){1'b0}}, cpu_en_q};
  end

  // Unpopulated channel codes read as zero; page-1 digits past bit 31 are blanked.
  always_comb begin
    word_s = 32'h0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (chan_sel_i == CH_SEL_W'(k)) word_s = probe_i[32*k +: 32];
    end
    if (page_sel_i) page_word_s = word_s >> PAGE_SHIFT;
    else            page_word_s = word_s;
    hex_d = '1;
    for (int d = 0; d < NUM_HEX; d++) begin
      if (page_sel_i && (NUM_HEX + d >= 8)) hex_d[7*d +: 7] = 7'h7F;
      else                                  hex_d[7*d +: 7] = seg7(page_word_s[4*d +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) hex_q <= '1;
    else       hex_q <= hex_d;
  end

  assign cpu_en_o = cpu_en_q;
  assign halted_o = halted_q;
  assign led_o    = step_q;
  assign hex_o    = hex_q;

endmodule

// File: tb/tb_debug_panel_ctrl.sv
// Directed self-checking bench for debug_panel_ctrl (DEBOUNCE_CYCLES=4, NUM_HEX=6).
module tb_debug_panel_ctrl;
  localparam int NUM_CH = 5, CH_SEL_W = 3, NUM_HEX = 6, DB = 4, LED_W = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 run_mode_i;
  logic                 step_key_n_i;
  logic [CH_SEL_W-1:0]  chan_sel_i;
  logic                 page_sel_i;
  logic [NUM_CH*32-1:0] probe_i;
  logic [31:0]          bp_addr_i;
  logic                 bp_valid_i;
  logic                 cpu_en_o;
  logic                 halted_o;
  logic [NUM_HEX*7-1:0] hex_o;
  logic [LED_W-1:0]     led_o;

  int checks = 0;
  int errors = 0;

  debug_panel_ctrl #(
    .NUM_CH(NUM_CH), .CH_SEL_W(CH_SEL_W), .NUM_HEX(NUM_HEX),
    .DEBOUNCE_CYCLES(DB), .LED_W(LED_W)
  ) dut (
    .clk(clk), .reset(reset), .run_mode_i(run_mode_i), .step_key_n_i(step_key_n_i),
    .chan_sel_i(chan_sel_i), .page_sel_i(page_sel_i), .probe_i(probe_i),
    .bp_addr_i(bp_addr_i), .bp_valid_i(bp_valid_i), .cpu_en_o(cpu_en_o),
    .halted_o(halted_o), .hex_o(hex_o), .led_o(led_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives the key low for 'hold' cycles (high at 'bounce_at'), then high for 'rel';
  // counts cpu_en_o pulses and the widest one.
  task automatic key_seq(input int hold, input int bounce_at, input int rel,
                         output int pulses, output int maxw);
    int w;
    w = 0; pulses = 0; maxw = 0;
    for (int i = 0; i < hold + rel; i++) begin
      step_key_n_i = (i < hold && i != bounce_at) ? 1'b0 : 1'b1;
      tick();
      if (cpu_en_o === 1'b1) begin
        if (w == 0) pulses++;
        w++;
        if (w > maxw) maxw = w;
      end else begin
        w = 0;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (cpu_en_o !== 1'b0) begin errors++; $display("FAIL reset_cpu_en: got %b want 0", cpu_en_o); end
    checks++; if (halted_o !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted_o); end
    checks++; if (led_o !== 8'h00) begin errors++; $display("FAIL reset_led: got %h want 00", led_o); end
    checks++; if (hex_o !== {NUM_HEX{7'h7F}}) begin errors++; $display("FAIL reset_hex: got %h want %h", hex_o, {NUM_HEX{7'h7F}}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_step;
    int p, w;
    run_mode_i = 1'b0;
    key_seq(20, 2, 20, p, w);
    checks++; if (p !== 1) begin errors++; $display("FAIL step_pulses: got %0d want 1", p); end
    checks++; if (w !== 1) begin errors++; $display("FAIL step_width: got %0d want 1", w); end
    checks++; if (led_o !== 8'd1) begin errors++; $display("FAIL step_led: got %0d want 1", led_o); end
  endtask

  task automatic test_run;
    int bad;
    bad = 0;
    run_mode_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cpu_en_o !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL run_en_high: got %0d low cycles want 0", bad); end
    run_mode_i = 1'b0;
    tick();
    checks++; if (cpu_en_o !== 1'b0) begin errors++; $display("FAIL run_en_drop: got %b want 0", cpu_en_o); end
    tick();
    checks++; if (led_o !== 8'd11) begin errors++; $display("FAIL run_led: got %0d want 11", led_o); end
  endtask

  task automatic test_display;
    probe_i = '0;
    probe_i[2*32 +: 32] = 32'h12ABCDEF;
    probe_i[1*32 +: 32] = 32'h88888888;
    chan_sel_i = 3'd2; page_sel_i = 1'b0;
    tick();
    checks++; if (hex_o !== {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}) begin errors++; $display("FAIL disp_page0: got %h want %h", hex_o, {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}); end
    page_sel_i = 1'b1;
    tick();
    checks++; if (hex_o !== {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24}) begin errors++; $display("FAIL disp_page1: got %h want %h", hex_o, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24}); end
    page_sel_i = 1'b0; chan_sel_i = 3'd1;
    tick();
    checks++; if (hex_o !== {NUM_HEX{7'h00}}) begin errors++; $display("FAIL disp_ch1_eights: got %h want %h", hex_o, {NUM_HEX{7'h00}}); end
    chan_sel_i = 3'd7;
    tick();
    checks++; if (hex_o !== {NUM_HEX{7'h40}}) begin errors++; $display("FAIL disp_ch7_zero: got %h want %h", hex_o, {NUM_HEX{7'h40}}); end
    chan_sel_i = 3'd5;
    tick();
    checks++; if (hex_o !== {NUM_HEX{7'h40}}) begin errors++; $display("FAIL disp_ch5_zero: got %h want %h", hex_o, {NUM_HEX{7'h40}}); end
  endtask

  task automatic test_breakpoint;
    int p, w;
    bp_addr_i = 32'h40; bp_valid_i = 1'b1;
    probe_i[31:0] = 32'h38;
    run_mode_i = 1'b1;
    tick(); tick();
    probe_i[31:0] = 32'h3C;
    tick();
    probe_i[31:0] = 32'h40;
    tick();
`ifdef DEBUG_PANEL_BP_EN
    checks++; if (halted_o !== 1'b1) begin errors++; $display("FAIL bp_halted: got %b want 1", halted_o); end
    checks++; if (cpu_en_o !== 1'b0) begin errors++; $display("FAIL bp_en_off: got %b want 0", cpu_en_o); end
    repeat (3) tick();
    checks++; if (halted_o !== 1'b1 || cpu_en_o !== 1'b0) begin errors++; $display("FAIL bp_hold: got halted=%b en=%b want 1/0", halted_o, cpu_en_o); end
    key_seq(10, -1, 10, p, w);
    checks++; if (p !== 1) begin errors++; $display("FAIL bp_press_pulses: got %0d want 1", p); end
    checks++; if (halted_o !== 1'b0 || cpu_en_o !== 1'b1) begin errors++; $display("FAIL bp_no_rehalt: got halted=%b en=%b want 0/1", halted_o, cpu_en_o); end
`else
    tick();
    checks++; if (halted_o !== 1'b0 || cpu_en_o !== 1'b1) begin errors++; $display("FAIL bp_disabled: got halted=%b en=%b want 0/1", halted_o, cpu_en_o); end
    key_seq(10, -1, 10, p, w);
    checks++; if (p !== 1 || w !== 20) begin errors++; $display("FAIL bp_disabled_run: got pulses=%0d width=%0d want 1/20", p, w); end
`endif
    run_mode_i = 1'b0;
    tick(); tick();
    checks++; if (cpu_en_o !== 1'b0 || halted_o !== 1'b0) begin errors++; $display("FAIL bp_exit: got en=%b halted=%b want 0/0", cpu_en_o, halted_o); end
    bp_valid_i = 1'b0;
  endtask

  task automatic test_wrap;
    int p, w;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_mode_i = 1'b1;
    repeat (255) tick();
    run_mode_i = 1'b0;
    tick();
    checks++; if (led_o !== 8'hFF) begin errors++; $display("FAIL wrap_ff: got %h want ff", led_o); end
    key_seq(10, -1, 10, p, w);
    checks++; if (led_o !== 8'h00) begin errors++; $display("FAIL wrap_00: got %h want 00", led_o); end
  endtask

  task automatic test_reset_in_pulse;
    int n, bad;
    run_mode_i = 1'b0;
    step_key_n_i = 1'b0;
    n = 0;
    while (cpu_en_o !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    checks++; if (cpu_en_o !== 1'b1) begin errors++; $display("FAIL rst_pulse_wait: got en=%b want 1 within 30 cycles", cpu_en_o); end
    reset = 1'b1; step_key_n_i = 1'b1;
    tick();
    checks++; if (cpu_en_o !== 1'b0 || led_o !== 8'h00) begin errors++; $display("FAIL rst_pulse_drop: got en=%b led=%h want 0/00", cpu_en_o, led_o); end
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cpu_en_o !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rst_pulse_idle: got %0d enabled cycles want 0", bad); end
  endtask

  initial begin
    reset = 1'b1; run_mode_i = 1'b0; step_key_n_i = 1'b1;
    chan_sel_i = '0; page_sel_i = 1'b0; probe_i = '0;
    bp_addr_i = 32'h0; bp_valid_i = 1'b0;
    test_reset();
    test_step();
    test_run();
    test_display();
    test_breakpoint();
    test_wrap();
    test_reset_in_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
